// File: rtl/uart_sync_fifo_pkg.sv
// Shared constants for the UART TX/RX FIFOs: output-mode selectors and the
// default geometry used by the UART instances.
package uart_fifo_pkg;

  localparam int FIFO_MODE_REG    = 0;
  localparam int FIFO_MODE_FWFT   = 1;

  localparam int UART_FIFO_DEPTH  = 16;
  localparam int UART_FIFO_DWIDTH = 8;

endpackage

// File: rtl/uart_sync_fifo_if.sv
// Bundle between the UART register side (master) and the FIFO (slave).
interface uart_sync_fifo_if import uart_fifo_pkg::*; #(
  parameter int DWIDTH = UART_FIFO_DWIDTH,
  parameter int DEPTH  = UART_FIFO_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  // writeEn/readEn are requests sampled every rising edge; a write is taken
  // when not FULL (or when a read is taken in the same cycle), and a read is
  // taken when not EMPTY. Refused requests raise the sticky error flags.
  logic              flush;
  logic              writeEn;
  logic [DWIDTH-1:0] dataIn;
  logic              readEn;
  logic              clr_err;
  logic [DWIDTH-1:0] dataOut;
  logic              EMPTY;
  logic              FULL;
  logic [AW:0]       count;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, writeEn, dataIn, readEn, clr_err,
    input  dataOut, EMPTY, FULL, count, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  flush, writeEn, dataIn, readEn, clr_err,
    output dataOut, EMPTY, FULL, count, almost_full, almost_empty,
           overflow, underflow
  );

endinterface

// File: rtl/uart_sync_fifo_ram.sv
// FIFO storage: register array with one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module uart_fifo_ram #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock UART FIFO: wrap-bit pointers so all DEPTH slots are usable,
// occupancy/threshold flags, sticky errors, flush and REG/FWFT output modes.
module uart_sync_fifo import uart_fifo_pkg::*; #(
  parameter int DWIDTH   = UART_FIFO_DWIDTH,
  parameter int DEPTH    = UART_FIFO_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter int FWFT     = FIFO_MODE_REG,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              reset,
  uart_sync_fifo_if.slave   bus
);

  localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_THR = (AW+1)'(AE_LEVEL);

  logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       count;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic [DWIDTH-1:0] rd_data;
  logic              empty, full, rd_ok, wr_ok;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;

  // Flush masks both requests, so it neither moves data nor flags errors.
  always_comb begin
    rd_ok  = bus.readEn  & ~empty & ~bus.flush;
    wr_ok  = bus.writeEn & (~full | rd_ok) & ~bus.flush;
    ovf_d  = (ovf_q & ~bus.clr_err) | (bus.writeEn & ~bus.flush & ~wr_ok);
    udf_d  = (udf_q & ~bus.clr_err) | (bus.readEn  & ~bus.flush & ~rd_ok);
    dout_d = dout_q;
    wptr_d = wptr_q + {{AW{1'b0}}, wr_ok};
    rptr_d = rptr_q + {{AW{1'b0}}, rd_ok};
    if (rd_ok) dout_d = rd_data;
    if (bus.flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      dout_q <= dout_d;
    end
  end

  uart_fifo_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (bus.dataIn),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign bus.dataOut      = (FWFT == FIFO_MODE_FWFT) ? rd_data : dout_q;
  assign bus.EMPTY        = empty;
  assign bus.FULL         = full;
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AF_THR);
  assign bus.almost_empty = (count <= AE_THR);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Bench for uart_sync_fifo: a registered-read and an FWFT instance (DEPTH=8)
// share one stimulus stream and are compared against a queue model.
module tb_uart_sync_fifo;
  import uart_fifo_pkg::*;

  localparam int DW = 8;
  localparam int DP = 8;

  logic clk;
  logic reset;

  uart_sync_fifo_if #(.DWIDTH(DW), .DEPTH(DP)) bus0 ();
  uart_sync_fifo_if #(.DWIDTH(DW), .DEPTH(DP)) bus1 ();

  uart_sync_fifo #(.DWIDTH(DW), .DEPTH(DP), .FWFT(FIFO_MODE_REG),
                   .AF_LEVEL(6), .AE_LEVEL(1))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));

  uart_sync_fifo #(.DWIDTH(DW), .DEPTH(DP), .FWFT(FIFO_MODE_FWFT),
                   .AF_LEVEL(6), .AE_LEVEL(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [DW-1:0] exp_q[$];
  bit            m_ovf, m_udf;
  logic [DW-1:0] m_dout;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
  endtask

  task automatic model_step(input bit fl, input bit we, input logic [DW-1:0] din,
                            input bit re, input bit clr);
    bit rd_ok, wr_ok;
    if (fl) begin
      exp_q.delete();
      m_ovf = m_ovf && !clr;
      m_udf = m_udf && !clr;
    end else begin
      rd_ok = re && (exp_q.size() != 0);
      wr_ok = we && ((exp_q.size() < DP) || rd_ok);
      m_ovf = (m_ovf && !clr) || (we && !wr_ok);
      m_udf = (m_udf && !clr) || (re && !rd_ok);
      if (rd_ok) m_dout = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(din);
    end
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    check("count0", 32'(bus0.count), 32'(n));
    check("count1", 32'(bus1.count), 32'(n));
    check("empty0", 32'(bus0.EMPTY), 32'(n == 0));
    check("empty1", 32'(bus1.EMPTY), 32'(n == 0));
    check("full0",  32'(bus0.FULL),  32'(n == DP));
    check("full1",  32'(bus1.FULL),  32'(n == DP));
    check("afull0", 32'(bus0.almost_full),  32'(n >= 6));
    check("aempty0", 32'(bus0.almost_empty), 32'(n <= 1));
    check("afull1", 32'(bus1.almost_full),  32'(n >= 6));
    check("aempty1", 32'(bus1.almost_empty), 32'(n <= 1));
    check("ovf0", 32'(bus0.overflow),  32'(m_ovf));
    check("udf0", 32'(bus0.underflow), 32'(m_udf));
    check("ovf1", 32'(bus1.overflow),  32'(m_ovf));
    check("udf1", 32'(bus1.underflow), 32'(m_udf));
    check("dout_reg", 32'(bus0.dataOut), 32'(m_dout));
    if (n != 0) check("dout_fwft", 32'(bus1.dataOut), 32'(exp_q[0]));
  endtask

  // driver
  task automatic drive(input bit fl, input bit we, input logic [DW-1:0] din,
                       input bit re, input bit clr);
    bus0.flush = fl;  bus0.writeEn = we; bus0.dataIn = din; bus0.readEn = re; bus0.clr_err = clr;
    bus1.flush = fl;  bus1.writeEn = we; bus1.dataIn = din; bus1.readEn = re; bus1.clr_err = clr;
  endtask

  task automatic step(input bit fl, input bit we, input logic [DW-1:0] din,
                      input bit re, input bit clr);
    @(negedge clk);
    drive(fl, we, din, re, clr);
    @(posedge clk);
    model_step(fl, we, din, re, clr);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic clr();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    while (exp_q.size() != 0) rd();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // fill to full, overflow, then read everything back in order
    for (int i = 1; i <= 8; i++) wr(DW'(i * 8'h11));
    wr(8'h99);
    for (int i = 0; i < 8; i++) rd();
    clr();

    // one in / one out across the pointer wrap
    wr(8'd0);
    for (int i = 1; i < 20; i++) step(1'b0, 1'b1, DW'(i), 1'b1, 1'b0);
    drain();

    // simultaneous read/write at FULL, then at EMPTY
    for (int i = 0; i < 8; i++) wr(DW'(8'h20 + i));
    step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    drain();
    step(1'b0, 1'b1, 8'h5C, 1'b1, 1'b0);
    drain();
    clr();

    // FWFT show-ahead: write to empty, then pop
    wr(8'h3C);
    idle();
    rd();

    // thresholds going up and down
    for (int i = 0; i < 8; i++) wr(DW'($urandom_range(0, 255)));
    drain();

    // flush with writes pending, then set-wins on clr_err
    for (int i = 0; i < 5; i++) wr(DW'(8'h40 + i));
    step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    clr();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 55,
           DW'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 8);
    end

    // asynchronous reset in the middle of a write burst
    for (int i = 0; i < 4; i++) wr(DW'(8'h70 + i));
    @(negedge clk);
    drive(1'b0, 1'b1, 8'hF0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    wr(8'h12);
    rd();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
